// File: rtl/fork_join_timer.sv
// Multi-channel delay dispatcher: launches up to NUM_CH delayed tasks and reports join-all/any/none completion.
// Latency: ch_done[i] pulses d[i]+1 cycles after the launch edge; join-none and empty launches signal done one cycle after launch.
// Backpressure: none; start is ignored while busy, and kill aborts everything in flight at the next edge.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, kill        launch request (ignored while busy) / abort of all active channels
//   mode[1:0]          join semantics latched at launch: 00 all, 01 any, 10 none, 11 all
//   ch_en, delay_i     per-channel enable and DLY_W-bit delay, latched at launch
//   busy, done         channels outstanding / one-cycle join pulse
//   ch_done, ch_active per-channel completion pulse / channel counting
//   done_time[15:0]    only with FJT_TIMESTAMP_EN defined: cycles from launch to the last done
module fork_join_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DLY_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      kill,
  input  logic [1:0]                mode,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*DLY_W-1:0]   delay_i,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_active
`ifdef FJT_TIMESTAMP_EN
  ,
  output logic [15:0]               done_time
`endif
);

  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0][DLY_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            ch_active_q, ch_active_d;
  logic [NUM_CH-1:0]            ch_done_q, ch_done_d;
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;
  logic [1:0]                   mode_q, mode_d;
  logic                         fired_q, fired_d;

  logic                         launch;
  logic [1:0]                   cur_mode;

`ifdef FJT_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  logic [15:0] done_time_q, done_time_d;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: counters, per-channel pulses and join evaluation.
  // ch_done is registered from the *next* counter value so the pulse is
  // visible in the same cycle the channel's counter reads zero.
  // ---------------------------------------------------------------------
  always_comb begin
    // busy_q can still be high in IDLE for the one cycle after a kill
    launch      = (state_q == IDLE) && start && !kill && !busy_q;
    cur_mode    = launch ? mode : mode_q;
    mode_d      = mode_q;
    fired_d     = fired_q;
    cnt_d       = cnt_q;
    ch_active_d = ch_active_q;
    ch_done_d   = '0;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    if (launch) begin
      mode_d  = mode;
      fired_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_active_d[i] = ch_en[i];
        cnt_d[i]       = ch_en[i] ? delay_i[i*DLY_W +: DLY_W] : '0;
        ch_done_d[i]   = ch_en[i] && (delay_i[i*DLY_W +: DLY_W] == '0);
      end
      // Empty launch joins immediately in every mode; join-none never waits
      if ((ch_en == '0) || (mode == MODE_NONE)) begin
        done_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (kill) begin
        ch_active_d = '0;
        cnt_d       = '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_active_q[i]) begin
            if (cnt_q[i] == '0) begin
              // pulse was shown this cycle; retire the channel
              ch_active_d[i] = 1'b0;
            end else begin
              cnt_d[i]     = cnt_q[i] - DLY_W'(1);
              ch_done_d[i] = (cnt_q[i] == DLY_W'(1));
            end
          end
        end
      end
    end

    // Join evaluation on the pulses about to be registered
    if (ch_done_d != '0) begin
      if (cur_mode == MODE_ANY) begin
        if (launch || !fired_q) begin
          done_d = 1'b1;
        end
        fired_d = 1'b1;
      end else if (cur_mode != MODE_NONE) begin
        // join-all: nothing left active except channels firing now
        if ((ch_active_d & ~ch_done_d) == '0) begin
          done_d = 1'b1;
        end
      end
    end

    // After kill, busy lingers one cycle so the abort is observable
    busy_d = ((state_q == RUN) && kill) ? 1'b1 : (|ch_active_d);
  end

`ifdef FJT_TIMESTAMP_EN
  // Free-running saturating cycle count restarted by each launch
  always_comb begin
    if (launch) begin
      ts_d = 16'd1;
    end else if (ts_q == 16'hFFFF) begin
      ts_d = ts_q;
    end else begin
      ts_d = ts_q + 16'd1;
    end
    done_time_d = done_d ? ts_d : done_time_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ch_active_q <= '0;
      ch_done_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 2'b00;
      fired_q     <= 1'b0;
`ifdef FJT_TIMESTAMP_EN
      ts_q        <= 16'd0;
      done_time_q <= 16'd0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      ch_active_q <= ch_active_d;
      ch_done_q   <= ch_done_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      fired_q     <= fired_d;
`ifdef FJT_TIMESTAMP_EN
      ts_q        <= ts_d;
      done_time_q <= done_time_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch && (ch_en != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (kill || (ch_active_d == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: all straight from flops
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    ch_done   = ch_done_q;
    ch_active = ch_active_q;
`ifdef FJT_TIMESTAMP_EN
    done_time = done_time_q;
`endif
  end

endmodule

// File: tb/tb_fork_join_timer.sv
module tb_fork_join_timer;

  localparam int NC = 3;
  localparam int DW = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               kill = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [NC-1:0]      ch_en = '0;
  logic [NC*DW-1:0]   delay_i = '0;
  logic               busy;
  logic               done;
  logic [NC-1:0]      ch_done;
  logic [NC-1:0]      ch_active;
`ifdef FJT_TIMESTAMP_EN
  logic [15:0]        done_time;
`endif

  fork_join_timer #(.NUM_CH(NC), .DLY_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kill      (kill),
    .mode      (mode),
    .ch_en     (ch_en),
    .delay_i   (delay_i),
    .busy      (busy),
    .done      (done),
    .ch_done   (ch_done),
    .ch_active (ch_active)
`ifdef FJT_TIMESTAMP_EN
    ,
    .done_time (done_time)
`endif
  );

  always #5 clk = ~clk;

  // Cycle numbers are relative to the launch edge T0: cycle 1 is the one
  // right after T0. -1 means "never".
  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] en;
    int d0; int d1; int d2;
    int kill_at;    // kill held high during this cycle
    int start2_at;  // extra start during this cycle (must be ignored)
    int cd0; int cd1; int cd2;
    int done_at;
    int busy_last;
    int ncyc;
  } vec_t;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [NC-1:0] chd;
    logic [NC-1:0] act;
  } exp_t;

  vec_t vecs[13];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cur_vec = -1;

  task automatic check(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d cycle %0d: got %0h expected %0h", nm, cur_vec, cyc, got, exp);
    end
  endtask

  function automatic int cd_of(input vec_t v, input int i);
    if (i == 0) return v.cd0;
    if (i == 1) return v.cd1;
    return v.cd2;
  endfunction

  function automatic exp_t expect_at(input vec_t v, input int m);
    exp_t e;
    int   cd;
    int   act_end;
    e.busy = (m >= 1) && (m <= v.busy_last);
    e.done = (m == v.done_at);
    for (int i = 0; i < NC; i++) begin
      cd = cd_of(v, i);
      act_end = (cd >= 0) ? cd : v.kill_at;
      e.chd[i] = (m == cd);
      e.act[i] = v.en[i] && (m >= 1) && (m <= act_end);
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    for (int n = 0; n < v.ncyc; n++) begin
      start = (n == 0) || (n == v.start2_at);
      kill  = (n == v.kill_at);
      if (n == 0) begin
        mode    = v.mode;
        ch_en   = v.en;
        delay_i = {DW'(v.d2), DW'(v.d1), DW'(v.d0)};
      end else begin
        // junk on the sampled-at-start inputs: must not be picked up
        mode    = ~v.mode;
        ch_en   = '1;
        delay_i = {NC{DW'(1)}};
      end
      sb_q.push_back(expect_at(v, n + 1));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", n + 1, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("busy",      n + 1, 32'(busy),      32'(e.busy));
        check("done",      n + 1, 32'(done),      32'(e.done));
        check("ch_done",   n + 1, 32'(ch_done),   32'(e.chd));
        check("ch_active", n + 1, 32'(ch_active), 32'(e.act));
`ifdef FJT_TIMESTAMP_EN
        if (e.done) check("done_time", n + 1, 32'(done_time), 32'(v.done_at));
`endif
      end
    end
    start = 1'b0;
    kill  = 1'b0;
  endtask

  task automatic reset_midrun();
    start   = 1'b1;
    mode    = 2'b00;
    ch_en   = 3'b111;
    delay_i = {DW'(10), DW'(7), DW'(30)};
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", 5, 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy",      5, 32'(busy),      32'd0);
    check("rst_done",      5, 32'(done),      32'd0);
    check("rst_ch_done",   5, 32'(ch_done),   32'd0);
    check("rst_ch_active", 5, 32'(ch_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      check("post_reset_quiet", k, 32'({busy, done, ch_done, ch_active}), 32'd0);
    end
  endtask

  initial begin
    //          mode   en      d0  d1  d2 kill st2 cd0 cd1 cd2 done busy ncyc
    vecs[0]  = '{2'b00, 3'b111, 30,  7, 10, -1, -1,  31,  8, 11,  31,  31,  34};
    vecs[1]  = '{2'b01, 3'b111, 30,  7, 10, -1, -1,  31,  8, 11,   8,  31,  34};
    vecs[2]  = '{2'b10, 3'b111, 30,  7, 10, -1,  5,  31,  8, 11,   1,  31,  34};
    vecs[3]  = '{2'b00, 3'b111,  0,  0,  5, -1, -1,   1,  1,  6,   6,   6,   9};
    vecs[4]  = '{2'b00, 3'b000,  3,  3,  3, -1, -1,  -1, -1, -1,   1,  -1,   3};
    vecs[5]  = '{2'b01, 3'b000,  3,  3,  3, -1, -1,  -1, -1, -1,   1,  -1,   3};
    vecs[6]  = '{2'b10, 3'b000,  3,  3,  3, -1, -1,  -1, -1, -1,   1,  -1,   3};
    vecs[7]  = '{2'b00, 3'b111, 30,  7, 10,  8, -1,  -1,  8, -1,  -1,   9,  14};
    vecs[8]  = '{2'b00, 3'b111,  2,  2,  2,  0, -1,  -1, -1, -1,  -1,  -1,   4};
    vecs[9]  = '{2'b11, 3'b101,  2,  5,  3, -1, -1,   3, -1,  4,   4,   4,   7};
    vecs[10] = '{2'b00, 3'b001, 255, 0,  0, -1, -1, 256, -1, -1, 256, 256, 259};
    vecs[11] = '{2'b01, 3'b111,  4,  4,  9, -1, -1,   5,  5, 10,   5,  10,  13};
    vecs[12] = '{2'b01, 3'b111,  3, 20, 20,  6, -1,   4, -1, -1,   4,   7,  10};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",      0, 32'(busy),      32'd0);
    check("reset_done",      0, 32'(done),      32'd0);
    check("reset_ch_done",   0, 32'(ch_done),   32'd0);
    check("reset_ch_active", 0, 32'(ch_active), 32'd0);
`ifdef FJT_TIMESTAMP_EN
    check("reset_done_time", 0, 32'(done_time), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      cur_vec = v;
      run_vec(vecs[v]);
    end

    cur_vec = 13;
    reset_midrun();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
